// File: rtl/fetch_flow_controller_if.sv
// rtl/fetch_flow_controller_if.sv - fetch control, i-cache request/response and queue-write signal bundle
interface fetch_flow_controller_if #(
  parameter int QUEUE_DEPTH     = 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ADDR_W          = 32
);
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  logic              fetch_enable;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              icache_req_valid;
  logic              icache_req_ready;
  logic [ADDR_W-1:0] icache_req_pc;
  logic              icache_rsp_valid;
  logic              q_wr_en;
  logic              q_pop;
  logic              q_flush;
  logic [CW-1:0]     credits;
  logic [OW-1:0]     outstanding;

  modport master (
    input  fetch_enable, redirect_valid, redirect_pc, icache_req_ready, icache_rsp_valid, q_pop,
    output icache_req_valid, icache_req_pc, q_wr_en, q_flush, credits, outstanding
  );

  modport slave (
    output fetch_enable, redirect_valid, redirect_pc, icache_req_ready, icache_rsp_valid, q_pop,
    input  icache_req_valid, icache_req_pc, q_wr_en, q_flush, credits, outstanding
  );
endinterface

// File: rtl/fetch_flow_controller.sv
// rtl/fetch_flow_controller.sv - credit-throttled sequential fetch with redirect flush and stale-response drop
module fetch_flow_controller #(
  parameter int                QUEUE_DEPTH     = 8,
  parameter int                MAX_OUTSTANDING = 4,
  parameter int                ADDR_W          = 32,
  parameter logic [ADDR_W-1:0] RESET_PC        = '0
) (
  input logic                     clk,
  input logic                     rst,
  fetch_flow_controller_if.master bus
);
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] pc, pc_next;
  logic [CW-1:0]     occ, occ_next;
  logic [OW-1:0]     out_cnt, out_next;
  logic [OW-1:0]     drop_cnt, drop_next;
  logic [CW-1:0]     credits;
  logic              req_valid, hs, wr_en, pop_eff;

  // Credits count slots neither occupied nor already promised to an in-flight request.
  assign credits = CW'(QUEUE_DEPTH) - occ - CW'(out_cnt);

  assign req_valid = (state == FETCH) && bus.fetch_enable && !bus.redirect_valid &&
                     (credits != '0) && (out_cnt < OW'(MAX_OUTSTANDING));
  assign hs        = req_valid && bus.icache_req_ready;
  assign wr_en     = bus.icache_rsp_valid && (drop_cnt == '0) && !bus.redirect_valid;
  assign pop_eff   = bus.q_pop && (occ != '0);

  assign bus.icache_req_valid = req_valid;
  assign bus.icache_req_pc    = pc;
  assign bus.q_wr_en          = wr_en;
  assign bus.q_flush          = bus.redirect_valid;
  assign bus.credits          = credits;
  assign bus.outstanding      = out_cnt;

  always_comb begin
    out_next   = out_cnt + OW'(hs) - OW'(bus.icache_rsp_valid);
    drop_next  = drop_cnt;
    occ_next   = occ + CW'(wr_en) - CW'(pop_eff);
    pc_next    = hs ? pc + ADDR_W'(4) : pc;
    state_next = state;

    if (bus.icache_rsp_valid && (drop_cnt != '0)) begin
      drop_next = drop_cnt - OW'(1);
    end

    // Every request still in flight after a redirect belongs to the old path.
    if (bus.redirect_valid) begin
      drop_next = out_next;
      occ_next  = '0;
      pc_next   = bus.redirect_pc;
    end

    case (state)
      IDLE:    state_next = bus.fetch_enable ? FETCH : IDLE;
      FETCH:   state_next = bus.fetch_enable ? FETCH : IDLE;
      DRAIN:   state_next = (drop_next == '0) ? (bus.fetch_enable ? FETCH : IDLE) : DRAIN;
      default: state_next = IDLE;
    endcase

    if (bus.redirect_valid && (out_next != '0)) begin
      state_next = DRAIN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      occ      <= '0;
      out_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      occ      <= occ_next;
      out_cnt  <= out_next;
      drop_cnt <= drop_next;
    end
  end

  rsp_needs_outstanding: assert property (@(posedge clk) disable iff (rst)
    bus.icache_rsp_valid |-> (out_cnt != '0));

  pop_needs_entry: assert property (@(posedge clk) disable iff (rst)
    bus.q_pop |-> (occ != '0));
endmodule

// File: tb/tb_fetch_flow_controller.sv
// tb/tb_fetch_flow_controller.sv - vector table, directed corner cases and randomized model check of fetch_flow_controller
module tb_fetch_flow_controller;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  fetch_flow_controller_if #(.QUEUE_DEPTH(8), .MAX_OUTSTANDING(4), .ADDR_W(32)) bus ();

  fetch_flow_controller #(
    .QUEUE_DEPTH(8), .MAX_OUTSTANDING(4), .ADDR_W(32), .RESET_PC(32'h0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic        fe, rdy, rsp, pop, redir;
    logic [31:0] rpc;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_wr, e_flush;
    logic [3:0]  e_cred;
    logic [2:0]  e_out;
  } vec_t;

  vec_t tbl [15];

  function automatic vec_t mk(input int fe, rdy, rsp, pop, redir, input logic [31:0] rpc,
                              input int ev, input logic [31:0] epc, input int ewr, efl, ecr, eout);
    vec_t r;
    r.fe = 1'(fe);      r.rdy = 1'(rdy);     r.rsp = 1'(rsp);  r.pop = 1'(pop);
    r.redir = 1'(redir); r.rpc = rpc;        r.e_valid = 1'(ev); r.e_pc = epc;
    r.e_wr = 1'(ewr);   r.e_flush = 1'(efl); r.e_cred = 4'(ecr); r.e_out = 3'(eout);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic fe, rdy, rsp, pop, redir, input logic [31:0] rpc);
    bus.fetch_enable     = fe;
    bus.icache_req_ready = rdy;
    bus.icache_rsp_valid = rsp;
    bus.q_pop            = pop;
    bus.redirect_valid   = redir;
    bus.redirect_pc      = rpc;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0, 32'h0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  logic [31:0] m_pc;
  int          m_occ, acc, wr_cnt, hs_cnt, e_cred, n_stale;
  bit          stale_q[$];
  bit          m_active, prev_redir, prev_hs, fe_r, e_valid, e_wr, rdy_r, rsp_r, pop_r, redir_r;
  logic [31:0] rpc_r;

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 32'h0);

    // Table: one row per cycle, outputs sampled mid-cycle.
    tbl[0]  = mk(1,0,0,0,0,32'h0,   0,32'h0,  0,0,8,0);
    tbl[1]  = mk(1,1,0,0,0,32'h0,   1,32'h0,  0,0,8,0);
    tbl[2]  = mk(1,1,0,0,0,32'h0,   1,32'h4,  0,0,7,1);
    tbl[3]  = mk(1,1,1,0,0,32'h0,   1,32'h8,  1,0,6,2);
    tbl[4]  = mk(1,0,0,0,1,32'h400, 0,32'hc,  0,1,5,2);
    tbl[5]  = mk(1,1,1,0,0,32'h0,   0,32'h400,0,0,6,2);
    tbl[6]  = mk(1,1,0,0,0,32'h0,   0,32'h400,0,0,7,1);
    tbl[7]  = mk(1,1,1,0,0,32'h0,   0,32'h400,0,0,7,1);
    tbl[8]  = mk(1,1,0,0,0,32'h0,   1,32'h400,0,0,8,0);
    tbl[9]  = mk(0,1,1,0,0,32'h0,   0,32'h404,1,0,7,1);
    tbl[10] = mk(0,0,0,1,0,32'h0,   0,32'h404,0,0,7,0);
    tbl[11] = mk(0,0,0,0,0,32'h0,   0,32'h404,0,0,8,0);
    tbl[12] = mk(1,0,0,0,1,32'h80,  0,32'h404,0,1,8,0);
    tbl[13] = mk(1,0,0,0,0,32'h0,   1,32'h80, 0,0,8,0);
    tbl[14] = mk(1,0,0,0,0,32'h0,   1,32'h80, 0,0,8,0);

    do_reset();
    @(negedge clk);
    chk("reset valid", bus.icache_req_valid, 0);
    chk("reset pc", bus.icache_req_pc, 32'h0);
    chk("reset credits", bus.credits, 8);
    chk("reset outstanding", bus.outstanding, 0);
    chk("reset wr_en", bus.q_wr_en, 0);
    chk("reset flush", bus.q_flush, 0);
    next_cycle();

    for (int i = 0; i < 15; i++) begin
      set_in(tbl[i].fe, tbl[i].rdy, tbl[i].rsp, tbl[i].pop, tbl[i].redir, tbl[i].rpc);
      @(negedge clk);
      chk($sformatf("vec%0d valid", i), bus.icache_req_valid, tbl[i].e_valid);
      chk($sformatf("vec%0d pc", i), bus.icache_req_pc, tbl[i].e_pc);
      chk($sformatf("vec%0d wr_en", i), bus.q_wr_en, tbl[i].e_wr);
      chk($sformatf("vec%0d flush", i), bus.q_flush, tbl[i].e_flush);
      chk($sformatf("vec%0d credits", i), bus.credits, tbl[i].e_cred);
      chk($sformatf("vec%0d outstanding", i), bus.outstanding, tbl[i].e_out);
      next_cycle();
    end

    // Fill the queue: responses one cycle after each accept, no pops.
    do_reset();
    acc = 0; wr_cnt = 0; prev_hs = 0;
    for (int c = 0; c < 20; c++) begin
      set_in(1, 1, prev_hs, 0, 0, 32'h0);
      @(negedge clk);
      prev_hs = bus.icache_req_valid && bus.icache_req_ready;
      if (prev_hs) begin
        chk($sformatf("fill pc%0d", acc), bus.icache_req_pc, 32'(acc * 4));
        acc++;
      end
      if (bus.q_wr_en) wr_cnt++;
      next_cycle();
    end
    @(negedge clk);
    chk("fill accepted", 32'(acc), 8);
    chk("fill wr_en count", 32'(wr_cnt), 8);
    chk("fill credits", bus.credits, 0);
    chk("fill outstanding", bus.outstanding, 0);
    next_cycle();

    // Single pop on a full queue frees exactly one request.
    set_in(1, 1, 0, 1, 0, 32'h0);
    @(negedge clk);
    chk("pop credits before", bus.credits, 0);
    next_cycle();
    hs_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      set_in(1, 1, 0, 0, 0, 32'h0);
      @(negedge clk);
      if (c == 0) chk("pop credits after", bus.credits, 1);
      if (bus.icache_req_valid && bus.icache_req_ready) begin
        hs_cnt++;
        chk("pop req pc", bus.icache_req_pc, 32'h20);
      end
      next_cycle();
    end
    chk("pop single issue", 32'(hs_cnt), 1);

    // Stall: pc and outstanding hold while ready is low.
    do_reset();
    repeat (3) begin
      set_in(1, 1, 0, 0, 0, 32'h0);
      next_cycle();
    end
    for (int c = 0; c < 5; c++) begin
      set_in(1, 0, 0, 0, 0, 32'h0);
      @(negedge clk);
      chk($sformatf("stall%0d pc", c), bus.icache_req_pc, 32'h8);
      chk($sformatf("stall%0d outstanding", c), bus.outstanding, 2);
      chk($sformatf("stall%0d valid", c), bus.icache_req_valid, 1);
      next_cycle();
    end

    // Redirect coincident with a response and a ready i-cache.
    do_reset();
    set_in(1, 1, 0, 0, 0, 32'h0);
    next_cycle();
    next_cycle();
    set_in(1, 1, 1, 0, 1, 32'h200);
    @(negedge clk);
    chk("redir+rsp valid", bus.icache_req_valid, 0);
    chk("redir+rsp wr_en", bus.q_wr_en, 0);
    chk("redir+rsp flush", bus.q_flush, 1);
    next_cycle();
    set_in(1, 1, 0, 0, 0, 32'h0);
    @(negedge clk);
    chk("redir+rsp next valid", bus.icache_req_valid, 1);
    chk("redir+rsp next pc", bus.icache_req_pc, 32'h200);
    chk("redir+rsp next outstanding", bus.outstanding, 0);
    chk("redir+rsp next credits", bus.credits, 8);
    next_cycle();

    // Asynchronous reset with two requests in flight.
    do_reset();
    set_in(1, 1, 0, 0, 0, 32'h0);
    repeat (3) next_cycle();
    #1 rst = 1'b1;
    #1;
    chk("async rst valid", bus.icache_req_valid, 0);
    chk("async rst outstanding", bus.outstanding, 0);
    chk("async rst credits", bus.credits, 8);
    chk("async rst wr_en", bus.q_wr_en, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    next_cycle();
    @(negedge clk);
    chk("post rst valid", bus.icache_req_valid, 1);
    chk("post rst pc", bus.icache_req_pc, 32'h0);
    next_cycle();

    // Randomized run against an in-flight-list model.
    do_reset();
    m_pc = 32'h0; m_occ = 0; m_active = 0; prev_redir = 0; fe_r = 1;
    stale_q.delete();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(fe_r ? 23 : 3) == 0) fe_r = !fe_r;
      rdy_r   = ($urandom_range(3) != 0);
      rsp_r   = (stale_q.size() > 0) && ($urandom_range(1) == 1);
      pop_r   = (m_occ > 0) && ($urandom_range(2) == 0);
      redir_r = !prev_redir && ($urandom_range(19) == 0);
      rpc_r   = ($urandom_range(3) == 0) ? 32'hffff_fff0 : ($urandom & 32'hffff_fffc);
      set_in(fe_r, rdy_r, rsp_r, pop_r, redir_r, rpc_r);

      e_cred  = 8 - m_occ - stale_q.size();
      e_valid = m_active && fe_r && !redir_r && (e_cred > 0) && (stale_q.size() < 4);
      e_wr    = rsp_r && !redir_r && !stale_q[0];

      @(negedge clk);
      chk("rnd valid", bus.icache_req_valid, e_valid);
      chk("rnd pc", bus.icache_req_pc, m_pc);
      chk("rnd wr_en", bus.q_wr_en, e_wr);
      chk("rnd flush", bus.q_flush, redir_r);
      chk("rnd credits", bus.credits, 32'(e_cred));
      chk("rnd outstanding", bus.outstanding, 32'(stale_q.size()));

      if (rsp_r) void'(stale_q.pop_front());
      if (e_wr) m_occ++;
      if (pop_r) m_occ--;
      if (e_valid && rdy_r) begin
        stale_q.push_back(1'b0);
        m_pc = m_pc + 32'd4;
      end
      if (redir_r) begin
        m_occ = 0;
        m_pc  = rpc_r;
        foreach (stale_q[i]) stale_q[i] = 1'b1;
      end
      n_stale = 0;
      foreach (stale_q[i]) if (stale_q[i]) n_stale++;
      m_active   = fe_r && (n_stale == 0);
      prev_redir = redir_r;
      next_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
